// File: rtl/alu_sweep_driver.sv
// Exhaustive operand sweep driver for a 4-bit ALU under test.
// Each result is folded into a 16-bit MISR signature, and each captured vector is counted.
module alu_sweep_driver #(
    parameter int          RESP_LAT = 1,
    parameter logic [15:0] SEED     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  op_mask,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_req,
    input  logic [7:0]  alu_res,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [9:0]  vec_count
);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPTURE, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = (RESP_LAT > 1) ? 3'(RESP_LAT - 2) : 3'd0;

    state_t      state_q, state_n;
    logic [3:0]  a_q, a_n, b_q, b_n, mask_q, mask_n;
    logic [1:0]  op_q, op_n;
    logic [15:0] sig_q, sig_n;
    logic [9:0]  cnt_q, cnt_n;
    logic [2:0]  wait_q, wait_n;
    logic [2:0]  first_op, next_op;

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
        logic fb;
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ {8'h00, r};
    endfunction

    // Lowest enabled opcode at or above 'from'; bit 2 set means none left.
    function automatic logic [2:0] pick_op(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] sel;
        sel = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) sel = 3'(i);
        end
        return sel;
    endfunction

    assign busy      = (state_q == DRIVE) || (state_q == WAIT) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign alu_req   = (state_q == DRIVE);
    assign alu_a     = busy ? a_q  : 4'd0;
    assign alu_b     = busy ? b_q  : 4'd0;
    assign alu_op    = busy ? op_q : 2'd0;
    assign signature = sig_q;
    assign vec_count = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 2'd0;
            mask_q  <= 4'd0;
            sig_q   <= SEED;
            cnt_q   <= 10'd0;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            op_q    <= op_n;
            mask_q  <= mask_n;
            sig_q   <= sig_n;
            cnt_q   <= cnt_n;
            wait_q  <= wait_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        op_n     = op_q;
        mask_n   = mask_q;
        sig_n    = sig_q;
        cnt_n    = cnt_q;
        wait_n   = wait_q;
        first_op = pick_op(op_mask, 3'd0);
        next_op  = pick_op(mask_q, {1'b0, op_q} + 3'd1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sig_n  = SEED;
                    cnt_n  = 10'd0;
                    mask_n = op_mask;
                    a_n    = 4'd0;
                    if (first_op[2]) begin
                        op_n    = 2'd0;
                        b_n     = 4'd0;
                        state_n = DONE;
                    end else begin
                        // Divide sweeps start at b=1 so b=0 is never presented.
                        op_n    = first_op[1:0];
                        b_n     = (first_op[1:0] == 2'd3) ? 4'd1 : 4'd0;
                        state_n = DRIVE;
                    end
                end
            end
            DRIVE: begin
                wait_n  = 3'd0;
                state_n = (RESP_LAT > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                if (wait_q == WAIT_LAST) state_n = CAPTURE;
                else                     wait_n  = wait_q + 3'd1;
            end
            CAPTURE: begin
                sig_n   = misr_step(sig_q, alu_res);
                cnt_n   = cnt_q + 10'd1;
                state_n = DRIVE;
                if (b_q != 4'd15) begin
                    b_n = b_q + 4'd1;
                end else if (a_q != 4'd15) begin
                    a_n = a_q + 4'd1;
                    b_n = (op_q == 2'd3) ? 4'd1 : 4'd0;
                end else if (next_op[2]) begin
                    state_n = DONE;
                end else begin
                    op_n = next_op[1:0];
                    a_n  = 4'd0;
                    b_n  = (next_op[1:0] == 2'd3) ? 4'd1 : 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Abort takes priority over any capture happening on the same edge.
        if (abort && busy) begin
            state_n = IDLE;
            sig_n   = sig_q;
            cnt_n   = cnt_q;
        end
    end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: two instances (RESP_LAT=1 and 3), each with a pipelined ALU model.
// Sweep results are compared against a bench-side sweep/MISR model.
module tb_alu_sweep_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_v, abort_v, sel, mon_clr;
    logic [3:0] mask_v;
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [3:0]  a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic        req0, req1, busy0, busy1, done0, done1;
    logic [7:0]  res0, res1, p1_s1, p1_s2;
    logic [15:0] sig0, sig1;
    logic [9:0]  cnt0, cnt1;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return {4'h0, a} + {4'h0, b};
            2'd1:    return {4'h0, a} * {4'h0, b};
            2'd2:    return {4'h0, a} - {4'h0, b};
            default: return (b == 4'd0) ? 8'hFF : {4'h0, a} / {4'h0, b};
        endcase
    endfunction

    always @(posedge clk) res0 <= alu_f(op0, a0, b0);
    always @(posedge clk) begin
        p1_s1 <= alu_f(op1, a1, b1);
        p1_s2 <= p1_s1;
        res1  <= p1_s2;
    end

    alu_sweep_driver #(.RESP_LAT(1), .SEED(16'hFFFF)) dut0 (
        .clk(clk), .rst(rst), .start(start_v & ~sel), .abort(abort_v & ~sel), .op_mask(mask_v),
        .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_req(req0), .alu_res(res0),
        .busy(busy0), .done(done0), .signature(sig0), .vec_count(cnt0));

    alu_sweep_driver #(.RESP_LAT(3), .SEED(16'hFFFF)) dut1 (
        .clk(clk), .rst(rst), .start(start_v & sel), .abort(abort_v & sel), .op_mask(mask_v),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_req(req1), .alu_res(res1),
        .busy(busy1), .done(done1), .signature(sig1), .vec_count(cnt1));

    wire [3:0]  a_c    = sel ? a1 : a0;
    wire [3:0]  b_c    = sel ? b1 : b0;
    wire [1:0]  op_c   = sel ? op1 : op0;
    wire        req_c  = sel ? req1 : req0;
    wire        busy_c = sel ? busy1 : busy0;
    wire        done_c = sel ? done1 : done0;
    wire [15:0] sig_c  = sel ? sig1 : sig0;
    wire [9:0]  cnt_c  = sel ? cnt1 : cnt0;
    wire [31:0] lat_c  = sel ? 32'd3 : 32'd1;

    logic [9:0] exp_vec [0:1007];
    int n_chk = 0, n_fail = 0;

    int req_cnt, order_err, space_err, zdiv, last_req_cyc;
    logic first_req;
    always @(negedge clk) begin
        if (mon_clr) begin
            req_cnt <= 0; order_err <= 0; space_err <= 0; zdiv <= 0;
            first_req <= 1'b1; last_req_cyc <= 0;
        end else if (req_c) begin
            req_cnt <= req_cnt + 1;
            if (req_cnt < 1008 && {op_c, a_c, b_c} !== exp_vec[req_cnt]) order_err <= order_err + 1;
            if (!first_req && (cyc - last_req_cyc) != int'(lat_c) + 1) space_err <= space_err + 1;
            if (op_c == 2'd3 && b_c == 4'd0) zdiv <= zdiv + 1;
            first_req    <= 1'b0;
            last_req_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Walks the sweep order with plain nested loops and folds results into a MISR.
    task automatic build_model(input logic [3:0] mask, input int limit, output logic [15:0] sig);
        int n;
        logic fb;
        logic [1:0] opv;
        logic [3:0] av, bv;
        sig = 16'hFFFF;
        n = 0;
        for (int op = 0; op < 4; op++) begin
            if (!mask[op]) continue;
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    if (op == 3 && b == 0) continue;
                    if (n >= limit) continue;
                    opv = 2'(op); av = 4'(a); bv = 4'(b);
                    exp_vec[n] = {opv, av, bv};
                    fb  = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
                    sig = {sig[14:0], fb} ^ {8'h00, alu_f(opv, av, bv)};
                    n++;
                end
            end
        end
    endtask

    typedef struct {
        int         d;
        logic [3:0] mask;
        int         restart;
        int         exp_cnt;
    } vec_t;

    task automatic begin_sweep(input logic [3:0] mask);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        mask_v  = mask;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
    endtask

    task automatic run_entry(input vec_t v);
        logic [15:0] esig;
        int k, lat;
        sel = (v.d != 0);
        lat = (v.d != 0) ? 3 : 1;
        build_model(v.mask, 2000, esig);
        begin_sweep(v.mask);
        check("busy_after_start", 32'(busy_c), 32'(v.mask != 4'd0));
        k = 0;
        while (!done_c && k < 6000) begin
            if (v.restart != 0) begin
                start_v = (k == 100 || k == 301);
                if (k == 50) mask_v = 4'b1111;
            end
            @(negedge clk);
            k++;
        end
        start_v = 1'b0;
        check("done_reached", 32'(done_c), 32'd1);
        check("sweep_cycles", 32'(k), 32'((1 + lat) * v.exp_cnt));
        check("vec_count", 32'(cnt_c), 32'(v.exp_cnt));
        check("signature", 32'(sig_c), 32'(esig));
        check("busy_in_done", 32'(busy_c), 32'd0);
        check("vector_zero_in_done", 32'({op_c, a_c, b_c, req_c}), 32'd0);
        check("req_pulses", 32'(req_cnt), 32'(v.exp_cnt));
        check("vector_order_errors", 32'(order_err), 32'd0);
        check("req_spacing_errors", 32'(space_err), 32'd0);
        check("div_by_zero_reqs", 32'(zdiv), 32'd0);
        repeat (2) @(negedge clk);
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        check("done_held", 32'(done_c), 32'd1);
        check("signature_held", 32'(sig_c), 32'(esig));
    endtask

    task automatic abort_test(input int d, input logic [3:0] mask, input int extra);
        logic [15:0] esig;
        int k;
        sel = (d != 0);
        build_model(mask, 10, esig);
        begin_sweep(mask);
        k = 0;
        while (cnt_c != 10'd10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_10", 32'(cnt_c), 32'd10);
        repeat (extra) @(negedge clk);
        abort_v = 1'b1;
        @(negedge clk);
        abort_v = 1'b0;
        check("abort_busy", 32'(busy_c), 32'd0);
        check("abort_done", 32'(done_c), 32'd0);
        check("abort_count", 32'(cnt_c), 32'd10);
        check("abort_signature", 32'(sig_c), 32'(esig));
        check("abort_vector_zero", 32'({op_c, a_c, b_c, req_c}), 32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'({busy_c, done_c, cnt_c}), 32'd10);
    endtask

    vec_t tbl [0:6];

    initial begin
        tbl[0] = '{0, 4'b0001, 0, 256};
        tbl[1] = '{0, 4'b1000, 0, 240};
        tbl[2] = '{0, 4'b0000, 0, 0};
        tbl[3] = '{1, 4'b1111, 0, 1008};
        tbl[4] = '{0, 4'b0110, 0, 512};
        tbl[5] = '{1, 4'b1010, 0, 496};
        tbl[6] = '{0, 4'b0001, 1, 256};

        rst = 1'b1; start_v = 1'b0; abort_v = 1'b0; mask_v = 4'd0; sel = 1'b0; mon_clr = 1'b1;
        #1;
        check("reset_dut0", 32'({busy0, done0, req0, op0, a0, b0, cnt0}), 32'd0);
        check("reset_sig0", 32'(sig0), 32'hFFFF);
        check("reset_dut1", 32'({busy1, done1, req1, op1, a1, b1, cnt1}), 32'd0);
        check("reset_sig1", 32'(sig1), 32'hFFFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_clr = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_entry(tbl[i]);

        abort_test(0, 4'b0001, 0);
        abort_test(0, 4'b0010, 1);
        abort_test(1, 4'b1000, 3);

        // Reset in the middle of a sweep must clear everything asynchronously.
        sel = 1'b1;
        begin_sweep(4'b1111);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", 32'({busy1, done1, req1}), 32'd0);
        check("midrst_vector", 32'({op1, a1, b1}), 32'd0);
        check("midrst_sig", 32'(sig1), 32'hFFFF);
        check("midrst_count", 32'(cnt1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 32'({busy1, done1, req1, cnt1}), 32'd0);

        run_entry('{0, 4'b0100, 0, 256});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
